// File: rtl/instr_mem_ctrl.sv
// Instruction memory with a registered fetch port, a run-time programming port
// and a post-reset NOP clear sweep, arbitrated by a CLEAR/RUN/PROG mode FSM.
module instr_mem_ctrl #(
   parameter int unsigned       ADDR_W     = 7,
   parameter int unsigned       DATA_W     = 32,
   parameter int unsigned       DEPTH      = 128,
   parameter logic [DATA_W-1:0] NOP        = '0,
   parameter bit                INIT_CLEAR = 1'b1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              fetch_req,
   input  logic [ADDR_W-1:0] fetch_addr,
   input  logic              fetch_stall,
   output logic              fetch_ready,
   output logic              fetch_valid,
   output logic [DATA_W-1:0] fetch_data,
   output logic              fetch_err,
   input  logic              prog_en,
   input  logic              prog_we,
   input  logic [ADDR_W-1:0] prog_addr,
   input  logic [DATA_W-1:0] prog_wdata,
   output logic              prog_ack,
   output logic              prog_err,
   output logic [ADDR_W:0]   prog_count,
   output logic              busy
);

   localparam logic [ADDR_W:0]   DEPTH_L  = (ADDR_W + 1)'(DEPTH);
   localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);
   localparam logic [ADDR_W:0]   CNT_MAX  = '1;

   typedef enum logic [1:0] {
      ST_CLEAR,
      ST_RUN,
      ST_PROG
   } state_t;

   state_t              state_q, state_d;
   logic [ADDR_W-1:0]   clr_cnt_q, clr_cnt_d;
   logic                fetch_valid_q, fetch_valid_d;
   logic [DATA_W-1:0]   fetch_data_q, fetch_data_d;
   logic                fetch_err_q, fetch_err_d;
   logic                prog_ack_q, prog_ack_d;
   logic                prog_err_q, prog_err_d;
   logic [ADDR_W:0]     prog_count_q, prog_count_d;

   logic [DATA_W-1:0]   mem_q [DEPTH];
   logic                mem_we;
   logic [ADDR_W-1:0]   mem_waddr;
   logic [DATA_W-1:0]   mem_wdata;

   logic                fetch_in_range;
   logic                prog_in_range;

   assign fetch_in_range = ({1'b0, fetch_addr} < DEPTH_L);
   assign prog_in_range  = ({1'b0, prog_addr} < DEPTH_L);

   always_comb begin
      state_d       = state_q;
      clr_cnt_d     = clr_cnt_q;
      fetch_valid_d = fetch_valid_q;
      fetch_data_d  = fetch_data_q;
      fetch_err_d   = fetch_err_q;
      prog_ack_d    = 1'b0;
      prog_err_d    = 1'b0;
      prog_count_d  = prog_count_q;
      mem_we        = 1'b0;
      mem_waddr     = clr_cnt_q;
      mem_wdata     = NOP;
      fetch_ready   = 1'b0;
      busy          = 1'b1;

      unique case (state_q)
         ST_CLEAR: begin
            mem_we        = 1'b1;
            fetch_valid_d = 1'b0;
            fetch_err_d   = 1'b0;
            if (clr_cnt_q == LAST_IDX) begin
               clr_cnt_d = '0;
               state_d   = ST_RUN;
            end else begin
               clr_cnt_d = clr_cnt_q + 1'b1;
            end
         end

         ST_RUN: begin
            busy        = 1'b0;
            fetch_ready = ~fetch_stall;
            if (fetch_req && !fetch_stall) begin
               fetch_valid_d = 1'b1;
               fetch_err_d   = ~fetch_in_range;
               fetch_data_d  = fetch_in_range ? mem_q[fetch_addr] : NOP;
            end else if (!fetch_stall) begin
               fetch_valid_d = 1'b0;
               fetch_err_d   = 1'b0;
            end
            // a fetch accepted alongside prog_en still lands on this edge
            if (prog_en) begin
               state_d      = ST_PROG;
               prog_count_d = '0;
            end
         end

         ST_PROG: begin
            fetch_valid_d = 1'b0;
            fetch_err_d   = 1'b0;
            if (prog_we) begin
               if (prog_in_range) begin
                  mem_we     = 1'b1;
                  mem_waddr  = prog_addr;
                  mem_wdata  = prog_wdata;
                  prog_ack_d = 1'b1;
                  if (prog_count_q != CNT_MAX) begin
                     prog_count_d = prog_count_q + 1'b1;
                  end
               end else begin
                  prog_err_d = 1'b1;
               end
            end
            if (!prog_en) begin
               state_d = ST_RUN;
            end
         end

         default: state_d = ST_RUN;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q       <= INIT_CLEAR ? ST_CLEAR : ST_RUN;
         clr_cnt_q     <= '0;
         fetch_valid_q <= 1'b0;
         fetch_data_q  <= NOP;
         fetch_err_q   <= 1'b0;
         prog_ack_q    <= 1'b0;
         prog_err_q    <= 1'b0;
         prog_count_q  <= '0;
      end else begin
         state_q       <= state_d;
         clr_cnt_q     <= clr_cnt_d;
         fetch_valid_q <= fetch_valid_d;
         fetch_data_q  <= fetch_data_d;
         fetch_err_q   <= fetch_err_d;
         prog_ack_q    <= prog_ack_d;
         prog_err_q    <= prog_err_d;
         prog_count_q  <= prog_count_d;
      end
   end

   // storage array carries no reset; the clear sweep initialises it
   always_ff @(posedge clk) begin
      if (mem_we) begin
         mem_q[mem_waddr] <= mem_wdata;
      end
   end

   assign fetch_valid = fetch_valid_q;
   assign fetch_data  = fetch_data_q;
   assign fetch_err   = fetch_err_q;
   assign prog_ack    = prog_ack_q;
   assign prog_err    = prog_err_q;
   assign prog_count  = prog_count_q;

endmodule
